// File: rtl/color_serializer.sv
// color_serializer: latches an RGB colour on start and streams it out one
// 4-bit digit per valid/ready handshake, with optional idle gaps between digits.
module color_serializer #(
  parameter int unsigned NIBBLES   = 6,
  parameter int unsigned GAP       = 0,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*NIBBLES-1:0]   color,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   ready,
  output logic [3:0]             nibble,
  output logic                   valid,
  output logic [2:0]             index,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned DATA_W = 4 * NIBBLES;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned GAP_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t              state, state_d;
  logic [DATA_W-1:0]   shreg, shreg_d;
  logic [IDX_W-1:0]    index_d;
  logic [GAP_W-1:0]    gap_cnt, gap_cnt_d;
  logic [3:0]          nibble_d;
  logic                valid_d;
  logic                busy_d;
  logic                done_d;
  logic                accept;
  logic [DATA_W-1:0]   shreg_next;

  // Digit currently at the head of the shift register for the chosen order.
  function automatic logic [3:0] head(input logic [DATA_W-1:0] s);
    if (MSB_FIRST) return s[DATA_W-1 -: 4];
    else           return s[3:0];
  endfunction

  // Shift register after the head digit has been consumed.
  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] s);
    if (MSB_FIRST) return s << 4;
    else           return s >> 4;
  endfunction

  assign accept     = valid & ready;
  assign shreg_next = advance(shreg);

  // State register and registered outputs; reset dominates all inputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      shreg   <= '0;
      index   <= '0;
      gap_cnt <= '0;
      nibble  <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      index   <= index_d;
      gap_cnt <= gap_cnt_d;
      nibble  <= nibble_d;
      valid   <= valid_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    index_d   = index;
    gap_cnt_d = gap_cnt;
    nibble_d  = 4'h0;
    valid_d   = 1'b0;
    done_d    = 1'b0;

    case (state)
      S_IDLE: begin
        index_d = '0;
        if (start && !abort) begin
          shreg_d  = color;
          state_d  = S_SEND;
          valid_d  = 1'b1;
          nibble_d = head(color);
        end
      end

      S_SEND: begin
        // Hold the presented digit until the consumer takes it.
        valid_d  = 1'b1;
        nibble_d = nibble;
        if (accept) begin
          if (index == IDX_W'(NIBBLES - 1)) begin
            state_d  = S_DONE;
            valid_d  = 1'b0;
            nibble_d = 4'h0;
            done_d   = 1'b1;
          end else begin
            shreg_d = shreg_next;
            index_d = index + IDX_W'(1);
            if (GAP == 0) begin
              nibble_d = head(shreg_next);
            end else begin
              state_d   = S_GAP;
              gap_cnt_d = GAP_W'(GAP - 1);
              valid_d   = 1'b0;
              nibble_d  = 4'h0;
            end
          end
        end
      end

      S_GAP: begin
        // Counter reaching zero marks the last idle cycle.
        if (gap_cnt == '0) begin
          state_d  = S_SEND;
          valid_d  = 1'b1;
          nibble_d = head(shreg);
        end else begin
          gap_cnt_d = gap_cnt - GAP_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        index_d = '0;
      end

      default: begin
        state_d = S_IDLE;
        index_d = '0;
      end
    endcase

    // Abort cancels any active transfer and discards the latched colour.
    if (abort && (state != S_IDLE)) begin
      state_d   = S_IDLE;
      shreg_d   = '0;
      index_d   = '0;
      gap_cnt_d = '0;
      nibble_d  = 4'h0;
      valid_d   = 1'b0;
      done_d    = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_color_serializer.sv
// Bench for color_serializer: default instance (GAP=0, MSB first) plus a
// GAP=2, LSB-first instance. Expected digits are queued at start and popped on accept.
module tb_color_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] color,  color2;
  logic        start,  abort,  ready;
  logic        start2, abort2, ready2;
  logic [3:0]  nibble, nibble2;
  logic        valid,  valid2;
  logic [2:0]  index,  index2;
  logic        busy,   busy2;
  logic        done,   done2;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [2:0] idx;
    logic [3:0] nib;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  color_serializer dut (
    .clk(clk), .reset(reset), .color(color), .start(start), .abort(abort),
    .ready(ready), .nibble(nibble), .valid(valid), .index(index),
    .busy(busy), .done(done)
  );

  color_serializer #(.NIBBLES(6), .GAP(2), .MSB_FIRST(1'b0)) dut_g (
    .clk(clk), .reset(reset), .color(color2), .start(start2), .abort(abort2),
    .ready(ready2), .nibble(nibble2), .valid(valid2), .index(index2),
    .busy(busy2), .done(done2)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue the six digits of c in transmission order.
  task automatic push_color(input logic [23:0] c, input bit msb);
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      e.idx = 3'(i);
      e.nib = msb ? c[23 - 4*i -: 4] : c[4*i +: 4];
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++; if (valid !== 1'b0)  begin fails++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (busy !== 1'b0)   begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)   begin fails++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (index !== 3'd0)  begin fails++; $display("FAIL reset_index got %0d want 0", index); end
    checks++; if (nibble !== 4'h0) begin fails++; $display("FAIL reset_nibble got %h want 0", nibble); end
    checks++; if (valid2 !== 1'b0 || busy2 !== 1'b0) begin
      fails++; $display("FAIL reset_gap_inst got valid=%b busy=%b want 0/0", valid2, busy2);
    end
    reset = 1'b1;
    step();
  endtask

  // Full transfer with ready high: valid on cycles 1..6, done only on cycle 7.
  task automatic test_basic();
    exp_t e;
    color = 24'hA1B2C3; start = 1'b1; ready = 1'b1;
    push_color(24'hA1B2C3, 1'b1);
    step();
    start = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      checks++; if (valid !== (cyc <= 6)) begin
        fails++; $display("FAIL basic_valid c%0d got %b want %b", cyc, valid, (cyc <= 6));
      end
      checks++; if (done !== (cyc == 7)) begin
        fails++; $display("FAIL basic_done c%0d got %b want %b", cyc, done, (cyc == 7));
      end
      checks++; if (busy !== (cyc <= 7)) begin
        fails++; $display("FAIL basic_busy c%0d got %b want %b", cyc, busy, (cyc <= 7));
      end
      if (valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; fails++; $display("FAIL basic_extra c%0d got nibble %h want none", cyc, nibble);
        end else begin
          e = exp_q.pop_front();
          checks++; if (nibble !== e.nib || index !== e.idx) begin
            fails++; $display("FAIL basic_data c%0d got %h/%0d want %h/%0d", cyc, nibble, index, e.nib, e.idx);
          end
        end
      end
      step();
    end
    checks++; if (exp_q.size() != 0) begin
      fails++; $display("FAIL basic_left got %0d pending want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  // Three stall cycles on index 1; order must be preserved.
  task automatic test_backpressure();
    exp_t e;
    int stalls = 0;
    bit seen_done = 0;
    color = 24'hA1B2C3; start = 1'b1; ready = 1'b1;
    push_color(24'hA1B2C3, 1'b1);
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 30 && !seen_done; cyc++) begin
      if (done === 1'b1) seen_done = 1;
      if (valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; fails++; $display("FAIL bp_extra got nibble %h want none", nibble);
        end else begin
          e = exp_q[0];
          checks++; if (nibble !== e.nib || index !== e.idx) begin
            fails++; $display("FAIL bp_data got %h/%0d want %h/%0d", nibble, index, e.nib, e.idx);
          end
          if (e.idx == 3'd1 && stalls < 3) begin
            ready = 1'b0;
            stalls++;
          end else begin
            ready = 1'b1;
            void'(exp_q.pop_front());
          end
        end
      end
      if (!seen_done) step();
    end
    checks++; if (!seen_done) begin fails++; $display("FAIL bp_done got timeout want done"); end
    checks++; if (stalls != 3 || exp_q.size() != 0) begin
      fails++; $display("FAIL bp_count got stalls=%0d pending=%0d want 3/0", stalls, exp_q.size());
    end
    ready = 1'b1;
    exp_q.delete();
    step();
  endtask

  // Abort after three accepts, abort beating start in idle, then a fresh transfer.
  task automatic test_abort();
    exp_t e;
    bit seen_done = 0;
    color = 24'hA1B2C3; start = 1'b1; ready = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    checks++; if (index !== 3'd3) begin fails++; $display("FAIL abort_pre got index %0d want 3", index); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL abort_stop got v=%b b=%b d=%b want 0/0/0", valid, busy, done);
    end
    step();
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL abort_nodone got %b want 0", done); end
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_wins got busy %b want 0", busy); end
    color = 24'hFFFFFF; start = 1'b1;
    push_color(24'hFFFFFF, 1'b1);
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen_done; cyc++) begin
      if (done === 1'b1) seen_done = 1;
      if (valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; fails++; $display("FAIL abort_extra got %h want none", nibble);
        end else begin
          e = exp_q.pop_front();
          checks++; if (nibble !== e.nib || index !== e.idx) begin
            fails++; $display("FAIL abort_data got %h/%0d want %h/%0d", nibble, index, e.nib, e.idx);
          end
        end
      end
      if (!seen_done) step();
    end
    checks++; if (!seen_done || exp_q.size() != 0) begin
      fails++; $display("FAIL abort_resend got done=%b pending=%0d want 1/0", seen_done, exp_q.size());
    end
    exp_q.delete();
    step();
  endtask

  // A start during a busy transfer must not disturb the latched colour.
  task automatic test_start_busy();
    exp_t e;
    bit seen_done = 0;
    color = 24'h123456; start = 1'b1; ready = 1'b1;
    push_color(24'h123456, 1'b1);
    step();
    start = 1'b0;
    for (int cyc = 1; cyc < 20 && !seen_done; cyc++) begin
      if (done === 1'b1) seen_done = 1;
      if (valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; fails++; $display("FAIL busy_extra got %h want none", nibble);
        end else begin
          e = exp_q.pop_front();
          checks++; if (nibble !== e.nib || index !== e.idx) begin
            fails++; $display("FAIL busy_data got %h/%0d want %h/%0d", nibble, index, e.nib, e.idx);
          end
        end
      end
      if (cyc == 3) begin color = 24'h000000; start = 1'b1; end
      else start = 1'b0;
      if (!seen_done) step();
    end
    checks++; if (!seen_done || exp_q.size() != 0) begin
      fails++; $display("FAIL busy_done got done=%b pending=%0d want 1/0", seen_done, exp_q.size());
    end
    step(); step();
    checks++; if (busy !== 1'b0 || valid !== 1'b0) begin
      fails++; $display("FAIL busy_dropped got b=%b v=%b want 0/0", busy, valid);
    end
    exp_q.delete();
  endtask

  // Reset mid-transfer at index 4, then a clean transfer afterwards.
  task automatic test_reset_mid();
    exp_t e;
    bit hit = 0;
    bit seen_done = 0;
    color = 24'hA1B2C3; start = 1'b1; ready = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 10 && !hit; cyc++) begin
      if (valid === 1'b1 && index === 3'd4) hit = 1;
      else step();
    end
    checks++; if (!hit) begin fails++; $display("FAIL rst_mid_reach got timeout want index 4"); end
    reset = 1'b0;
    step();
    checks++; if (valid !== 1'b0 || busy !== 1'b0 || index !== 3'd0 || done !== 1'b0) begin
      fails++; $display("FAIL rst_mid got v=%b b=%b i=%0d d=%b want 0/0/0/0", valid, busy, index, done);
    end
    reset = 1'b1;
    step();
    color = 24'h0F0F0F; start = 1'b1;
    push_color(24'h0F0F0F, 1'b1);
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen_done; cyc++) begin
      if (done === 1'b1) seen_done = 1;
      if (valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; fails++; $display("FAIL rst_extra got %h want none", nibble);
        end else begin
          e = exp_q.pop_front();
          checks++; if (nibble !== e.nib || index !== e.idx) begin
            fails++; $display("FAIL rst_data got %h/%0d want %h/%0d", nibble, index, e.nib, e.idx);
          end
        end
      end
      if (!seen_done) step();
    end
    checks++; if (!seen_done || exp_q.size() != 0) begin
      fails++; $display("FAIL rst_after got done=%b pending=%0d want 1/0", seen_done, exp_q.size());
    end
    exp_q.delete();
    step();
  endtask

  // GAP=2, LSB first: digits 3,C,2,B,1,A with exactly two idle cycles between.
  task automatic test_gap_lsb();
    exp_t e;
    bit seen_done = 0;
    bit seen_valid = 0;
    int idle = 0;
    color2 = 24'hA1B2C3; start2 = 1'b1; ready2 = 1'b1;
    push_color(24'hA1B2C3, 1'b0);
    step();
    start2 = 1'b0;
    checks++; if (valid2 !== 1'b1) begin fails++; $display("FAIL gap_latency got %b want 1", valid2); end
    for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
      if (done2 === 1'b1) seen_done = 1;
      if (valid2 === 1'b1) begin
        if (seen_valid) begin
          checks++; if (idle != 2) begin fails++; $display("FAIL gap_len got %0d want 2", idle); end
        end
        seen_valid = 1;
        idle = 0;
        if (exp_q.size() == 0) begin
          checks++; fails++; $display("FAIL gap_extra got %h want none", nibble2);
        end else begin
          e = exp_q.pop_front();
          checks++; if (nibble2 !== e.nib || index2 !== e.idx) begin
            fails++; $display("FAIL gap_data got %h/%0d want %h/%0d", nibble2, index2, e.nib, e.idx);
          end
        end
      end else begin
        idle++;
        checks++; if (nibble2 !== 4'h0) begin fails++; $display("FAIL gap_idle_nib got %h want 0", nibble2); end
      end
      if (!seen_done) step();
    end
    checks++; if (!seen_done || exp_q.size() != 0) begin
      fails++; $display("FAIL gap_done got done=%b pending=%0d want 1/0", seen_done, exp_q.size());
    end
    exp_q.delete();
    step();
  endtask

  initial begin
    reset = 1'b0;
    color = '0;  start = 1'b0;  abort = 1'b0;  ready = 1'b0;
    color2 = '0; start2 = 1'b0; abort2 = 1'b0; ready2 = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_abort();
    test_start_busy();
    test_reset_mid();
    test_gap_lsb();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
